// File: rtl/uart_rx_multimode.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_multimode
// Description : Parametrised UART receiver. Configurable data bits, parity,
//               stop bits and oversample rate, with a runtime baud divisor.
//               Uses majority-vote mid-bit sampling and rejects false starts.
//               Reports framing and parity errors. Output is a valid/ready
//               holding register with overrun detection.
//               Optional break detection: define UART_RX_BREAK_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_multimode #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OS_RATE     = 16,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int c_os_w  = $clog2(OS_RATE);
    localparam int c_bit_w = $clog2(DATA_BITS);
    localparam logic [c_os_w-1:0]  c_os_mid   = c_os_w'(OS_RATE / 2);
    localparam logic [c_os_w-1:0]  c_os_last  = c_os_w'(OS_RATE - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_BITS - 1);
    localparam logic               c_stop_last = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    // Baud tick generator
    logic [DIV_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic [DIV_WIDTH-1:0] w_div_last;
    logic                 w_tick;

    // Synchroniser and vote history
    logic [1:0] sync_q, sync_d;
    logic [2:0] hist_q, hist_d;
    logic       w_rx_s, w_rx_v;

    // Frame FSM
    state_t               state_q, state_d;
    logic [c_os_w-1:0]    os_cnt_q, os_cnt_d;
    logic [c_bit_w-1:0]   bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_pend_q, perr_pend_d;
    logic                 ferr_pend_q, ferr_pend_d;
    logic                 w_par_exp;
    logic                 w_commit;

    // Output holding register
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;

    // Counter wraps when it reaches (or has been left above) the last count
    always_comb begin
        w_div_last = (baud_div == '0) ? '0 : baud_div - DIV_WIDTH'(1);
        w_tick     = (tick_cnt_q >= w_div_last);
        tick_cnt_d = w_tick ? '0 : tick_cnt_q + DIV_WIDTH'(1);
    end

    // Two-flop synchroniser every clock; vote history shifts on ticks only
    always_comb begin
        sync_d = {sync_q[0], rx};
        w_rx_s = sync_q[1];
        hist_d = w_tick ? {hist_q[1:0], w_rx_s} : hist_q;
        w_rx_v = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
        w_par_exp = (^shreg_q) ^ (PARITY_MODE == 2);
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic ones_seen_q, ones_seen_d;
    logic brk_q, brk_d;
    logic w_break;
    logic w_break_frame;

    // Remember whether any data or parity sample of this frame was a 1
    always_comb begin
        ones_seen_d = ones_seen_q;
        if (w_tick && state_q == ST_IDLE) begin
            ones_seen_d = 1'b0;
        end else if (w_tick && (state_q == ST_DATA || state_q == ST_PARITY) &&
                     os_cnt_q == c_os_mid && w_rx_v) begin
            ones_seen_d = 1'b1;
        end
        w_break_frame = ~ones_seen_q & (ferr_pend_q | ~w_rx_v);
        brk_d         = w_break;
    end

    // Break tracking registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_seen_q <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            ones_seen_q <= ones_seen_d;
            brk_q       <= brk_d;
        end
    end

    assign break_det = brk_q;
`else
    assign break_det = 1'b0;
`endif

    // Frame FSM next state; all sampling happens at mid-bit ticks
    always_comb begin
        state_d     = state_q;
        os_cnt_d    = os_cnt_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        shreg_d     = shreg_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        w_commit    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        w_break     = 1'b0;
`endif
        if (w_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        state_d     = ST_START;
                        os_cnt_d    = '0;
                        perr_pend_d = 1'b0;
                        ferr_pend_d = 1'b0;
                    end
                end
                ST_START: begin
                    os_cnt_d = os_cnt_q + c_os_w'(1);
                    if (os_cnt_q == c_os_mid && w_rx_v) begin
                        state_d = ST_IDLE;
                    end else if (os_cnt_q == c_os_last) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end
                end
                ST_DATA: begin
                    os_cnt_d = os_cnt_q + c_os_w'(1);
                    if (os_cnt_q == c_os_mid) begin
                        shreg_d = {w_rx_v, shreg_q[DATA_BITS-1:1]};
                    end
                    if (os_cnt_q == c_os_last) begin
                        if (bit_idx_q == c_bit_last) begin
                            state_d    = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                            stop_idx_d = 1'b0;
                        end else begin
                            bit_idx_d = bit_idx_q + c_bit_w'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    os_cnt_d = os_cnt_q + c_os_w'(1);
                    if (os_cnt_q == c_os_mid && (w_rx_v != w_par_exp)) begin
                        perr_pend_d = 1'b1;
                    end
                    if (os_cnt_q == c_os_last) begin
                        state_d    = ST_STOP;
                        stop_idx_d = 1'b0;
                    end
                end
                ST_STOP: begin
                    os_cnt_d = os_cnt_q + c_os_w'(1);
                    if (os_cnt_q == c_os_mid) begin
                        if (!w_rx_v) begin
                            ferr_pend_d = 1'b1;
                        end
                        // Finish at the last stop mid-sample so a back-to-back start edge is seen
                        if (stop_idx_q == c_stop_last) begin
`ifdef UART_RX_BREAK_DETECT_EN
                            if (w_break_frame) begin
                                w_break = 1'b1;
                                state_d = ST_WAIT_IDLE;
                            end else begin
                                w_commit = 1'b1;
                                state_d  = ST_IDLE;
                            end
`else
                            w_commit = 1'b1;
                            state_d  = ST_IDLE;
`endif
                        end
                    end else if (os_cnt_q == c_os_last) begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (w_rx_v) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Holding register: a commit always wins, consumption clears valid otherwise
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        ovr_d   = 1'b0;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (w_commit) begin
            data_d  = shreg_q;
            ferr_d  = ferr_pend_q | ~w_rx_v;
            perr_d  = perr_pend_q;
            valid_d = 1'b1;
            ovr_d   = valid_q & ~ready;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q  <= '0;
            sync_q      <= 2'b11;
            hist_q      <= 3'b111;
            state_q     <= ST_IDLE;
            os_cnt_q    <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shreg_q     <= '0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            state_q     <= state_d;
            os_cnt_q    <= os_cnt_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            shreg_q     <= shreg_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            perr_q      <= perr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_multimode.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_multimode
// Description : Self-checking bench. dut_a is 8N1, dut_b is even parity with
//               two stop bits. Expected words are queued when a frame is
//               driven and compared when the consumer accepts it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_multimode;

    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_a, rx_b, ready_a, ready_b;
    logic [15:0] baud_div;
    logic [7:0]  data_a, data_b;
    logic        valid_a, ferr_a, perr_a, ovr_a, brk_a;
    logic        valid_b, ferr_b, perr_b, ovr_b, brk_b;

    always #5 clk = ~clk;

    uart_rx_multimode #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OS_RATE(16), .DIV_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .baud_div(baud_div), .data(data_a), .valid(valid_a),
        .ready(ready_a), .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a), .break_det(brk_a));

    uart_rx_multimode #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2), .OS_RATE(16), .DIV_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .baud_div(baud_div), .data(data_b), .valid(valid_b),
        .ready(ready_b), .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b), .break_det(brk_b));

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        int         inst;
        logic [7:0] d;
        logic       pbit;
        logic       s1;
        logic       s2;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t vecs[12];
    logic sb_en = 1'b1;

    int         ovr_cnt_a = 0;
    int         brk_cnt_a = 0;
    int         cap_cnt_a = 0;
    int         val_cyc_a = 0;
    logic [7:0] cap_first_d = 8'h00;
    logic       cap_first_f = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard: compare each accepted word with the oldest expectation
    always begin
        @(negedge clk);
        #1;
        if (!rst && sb_en && valid_a && ready_a) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_a_unexpected got=0x%0h exp=none", data_a);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("sb_a_data", data_a, e.d);
                check("sb_a_ferr", ferr_a, e.ferr);
                check("sb_a_perr", perr_a, e.perr);
            end
        end
        if (!rst && sb_en && valid_b && ready_b) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_b_unexpected got=0x%0h exp=none", data_b);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("sb_b_data", data_b, e.d);
                check("sb_b_ferr", ferr_b, e.ferr);
                check("sb_b_perr", perr_b, e.perr);
            end
        end
    end

    // Event counters for the multi-cycle corner cases
    always begin
        @(negedge clk);
        #1;
        if (ovr_a) ovr_cnt_a++;
        if (brk_a) brk_cnt_a++;
        if (valid_a) val_cyc_a++;
        if (valid_a && ready_a) begin
            if (cap_cnt_a == 0) begin
                cap_first_d = data_a;
                cap_first_f = ferr_a;
            end
            cap_cnt_a++;
        end
    end

    task automatic push_exp(input int inst, input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.d = d;
        e.perr = p;
        e.ferr = f;
        if (inst == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    task automatic set_rx(input int inst, input logic v);
        if (inst == 0) rx_a = v;
        else rx_b = v;
    endtask

    task automatic hold_bit(input int inst, input logic v, input int div);
        set_rx(inst, v);
        repeat (div * OS) @(negedge clk);
    endtask

    // dut_b frames carry a parity bit and two stop bits
    task automatic send_frame(input int inst, input logic [7:0] d, input logic pbit,
                              input logic s1, input logic s2, input int div);
        hold_bit(inst, 1'b0, div);
        for (int i = 0; i < 8; i++) hold_bit(inst, d[i], div);
        if (inst == 1) hold_bit(inst, pbit, div);
        hold_bit(inst, s1, div);
        if (inst == 1) hold_bit(inst, s2, div);
        if ((inst == 1) ? !s2 : !s1) hold_bit(inst, 1'b1, div);
        set_rx(inst, 1'b1);
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, (q_a.size() == 0 && q_b.size() == 0)}, 32'd1);
    endtask

    task automatic reset_mid_frame(input int div_before, input int div_after, input string tag);
        hold_bit(0, 1'b0, div_before);
        hold_bit(0, 1'b1, div_before);
        hold_bit(0, 1'b1, div_before);
        hold_bit(0, 1'b0, div_before);
        rx_a = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_rst_valid"}, valid_a, 0);
        check({tag, "_rst_data"}, data_a, 0);
        rst = 1'b0;
        baud_div = 16'(div_after);
        repeat (20) @(negedge clk);
        check({tag, "_no_partial"}, valid_a, 0);
        push_exp(0, 8'h3C, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1, div_after);
        wait_drain({tag, "_drain"}, 20 * div_after * OS);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0; baud_div = 16'd54;
        vecs[0]  = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[2]  = '{0, 8'h81, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1};
        vecs[3]  = '{0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[4]  = '{1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[5]  = '{1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[6]  = '{1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{1, 8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[8]  = '{1, 8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0};
        vecs[9]  = '{1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1};
        vecs[10] = '{1, 8'h96, 1'b0, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0};
        vecs[11] = '{1, 8'h69, 1'b0, 1'b1, 1'b1, 8'h69, 1'b0, 1'b0};

        repeat (5) @(negedge clk);
        check("rst_data_a", data_a, 0);
        check("rst_valid_a", valid_a, 0);
        check("rst_flags_a", {ferr_a, perr_a, ovr_a, brk_a}, 0);
        check("rst_data_b", data_b, 0);
        check("rst_valid_b", valid_b, 0);
        check("rst_flags_b", {ferr_b, perr_b, ovr_b, brk_b}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 0xA5 at 115200 bps, held until the consumer takes it
        push_exp(0, 8'hA5, 1'b0, 1'b0);
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 54);
        check("t1_valid", valid_a, 1);
        check("t1_data", data_a, 8'hA5);
        check("t1_flags", {ferr_a, perr_a}, 0);
        repeat (10) @(negedge clk);
        check("t1_valid_held", valid_a, 1);
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        check("t1_valid_drop", valid_a, 0);

        // Table of frames at a fast baud with the consumer always ready
        baud_div = 16'd4;
        ready_a = 1'b1;
        ready_b = 1'b1;
        repeat (100) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            push_exp(vecs[i].inst, vecs[i].ed, vecs[i].ep, vecs[i].ef);
            send_frame(vecs[i].inst, vecs[i].d, vecs[i].pbit, vecs[i].s1, vecs[i].s2, 4);
        end
        wait_drain("table_drain", 2000);

        // One-tick glitch on an idle line must not produce a word
        ready_a = 1'b0;
        val_cyc_a = 0;
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (3 * 64) @(negedge clk);
        check("glitch_no_valid", val_cyc_a, 0);
        ready_a = 1'b1;
        push_exp(0, 8'h55, 1'b0, 1'b0);
        send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, 4);
        wait_drain("glitch_drain", 2000);

        // Three words with no consumer: newest kept, two overruns
        ready_a = 1'b0;
        repeat (20) @(negedge clk);
        ovr_cnt_a = 0;
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, 4);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, 4);
        send_frame(0, 8'h33, 1'b0, 1'b1, 1'b1, 4);
        check("ovr_valid", valid_a, 1);
        check("ovr_data", data_a, 8'h33);
        check("ovr_pulses", ovr_cnt_a, 2);
        push_exp(0, 8'h33, 1'b0, 1'b0);
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        check("ovr_valid_drop", valid_a, 0);
        wait_drain("ovr_drain", 10);

        // Line held low for three frame times
        sb_en = 1'b0;
        ready_a = 1'b1;
        brk_cnt_a = 0;
        cap_cnt_a = 0;
        rx_a = 1'b0;
        repeat (3 * 10 * 64) @(negedge clk);
        rx_a = 1'b1;
        repeat (2 * 10 * 64) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
        check("brk_pulses", brk_cnt_a, 1);
        check("brk_no_valid", cap_cnt_a, 0);
`else
        check("brk_tied_low", brk_cnt_a, 0);
        check("brk_repeat_frames", {31'd0, (cap_cnt_a >= 2)}, 32'd1);
        check("brk_first_data", cap_first_d, 8'h00);
        check("brk_first_ferr", cap_first_f, 1);
`endif
        sb_en = 1'b1;
        push_exp(0, 8'h7E, 1'b0, 1'b0);
        send_frame(0, 8'h7E, 1'b0, 1'b1, 1'b1, 4);
        wait_drain("brk_after_drain", 2000);

        // Reset mid-frame, then a clean word; second pass changes the baud
        reset_mid_frame(4, 4, "rst1");
        baud_div = 16'd54;
        repeat (20) @(negedge clk);
        reset_mid_frame(54, 27, "rst2");

        check("final_queue_a", q_a.size(), 0);
        check("final_queue_b", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
